// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   state_e  : FSM encoding (IDLE, RUN, DONE)
//   RES_*    : result classification latched on accept, applied in DONE
//   cnt_w()  : step-counter width for a given operand width
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] RES_OK  = 2'd0;
  localparam logic [1:0] RES_DZ  = 2'd1;
  localparam logic [1:0] RES_OVF = 2'd2;

  // Counter only has to reach W-1; keep at least one bit.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step (combinational).
//   prem_i : partial remainder, W+1 bits
//   dvs_i  : divisor magnitude, W bits
//   bit_i  : next dividend bit (MSB first)
//   prem_o : updated partial remainder, W+1 bits
//   qbit_o : quotient bit produced by this step
module div_step #(
  parameter int W = 16
) (
  input  logic [W:0]   prem_i,
  input  logic [W-1:0] dvs_i,
  input  logic         bit_i,
  output logic [W:0]   prem_o,
  output logic         qbit_o
);

  logic [W:0] shifted;

  // The shift drops prem_i[W]; if it were set the true shifted value would
  // exceed the divisor anyway, so it forces a subtract. The subtraction
  // modulo 2^(W+1) still yields the exact remainder.
  assign shifted = {prem_i[W-1:0], bit_i};
  assign qbit_o  = prem_i[W] | (shifted >= {1'b0, dvs_i});
  assign prem_o  = qbit_o ? (shifted - {1'b0, dvs_i}) : shifted;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with start/busy/valid handshake.
//   clk, rst (sync, active high)
//   start, numerator[W], denominator[W] : request, sampled when busy=0
//   busy        : high in RUN and DONE
//   valid       : one-cycle pulse, results registered out of DONE
//   quotient[OUT_W], remainder[W], error, ovf : held until next update
module seq_divider
  import div_pkg::*;
#(
  parameter int W      = 16,
  parameter int OUT_W  = 32,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     numerator,
  input  logic [W-1:0]     denominator,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] quotient,
  output logic [W-1:0]     remainder,
  output logic             error,
  output logic             ovf
);

  localparam int            CW       = cnt_w(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [W-1:0]  NUM_MIN  = {1'b1, {(W-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W:0]       prem_q, prem_d;
  // Dividend shifts out at the MSB while quotient bits shift in at the LSB;
  // after W steps it holds the quotient magnitude.
  logic [W-1:0]     dvd_q, dvd_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic             num_neg_q, num_neg_d;
  logic             q_neg_q, q_neg_d;
  logic [1:0]       code_q, code_d;
  logic [OUT_W-1:0] quot_q, quot_d;
  logic [W-1:0]     rem_q, rem_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic [W:0]       step_prem;
  logic             step_qbit;
  logic             num_neg, den_neg;
  logic [W-1:0]     num_mag, den_mag;
  logic [W-1:0]     q_fix, r_fix;
  logic [OUT_W-1:0] q_ext;

  div_step #(.W(W)) u_step (
    .prem_i (prem_q),
    .dvs_i  (dvs_q),
    .bit_i  (dvd_q[W-1]),
    .prem_o (step_prem),
    .qbit_o (step_qbit)
  );

  assign num_neg = (SIGNED != 0) && numerator[W-1];
  assign den_neg = (SIGNED != 0) && denominator[W-1];
  assign num_mag = num_neg ? W'(-numerator)   : numerator;
  assign den_mag = den_neg ? W'(-denominator) : denominator;

  // MIN/-1 needs no special datapath: magnitude 2^(W-1), no negation,
  // reads back as -2^(W-1) after sign extension.
  assign q_fix = q_neg_q   ? W'(-dvd_q)          : dvd_q;
  assign r_fix = num_neg_q ? W'(-prem_q[W-1:0])  : prem_q[W-1:0];

  always_comb begin
    q_ext = '0;
    q_ext[W-1:0] = q_fix;
    for (int i = W; i < OUT_W; i++) q_ext[i] = (SIGNED != 0) ? q_fix[W-1] : 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prem_d    = prem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    num_neg_d = num_neg_q;
    q_neg_d   = q_neg_q;
    code_d    = code_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d     = den_mag;
          prem_d    = '0;
          cnt_d     = '0;
          num_neg_d = num_neg;
          q_neg_d   = num_neg ^ den_neg;
          if (denominator == '0) begin
            // Raw numerator kept so it can be returned as the remainder.
            dvd_d   = numerator;
            code_d  = RES_DZ;
            state_d = DONE;
          end else begin
            dvd_d   = num_mag;
            code_d  = ((SIGNED != 0) && numerator == NUM_MIN && denominator == '1)
                      ? RES_OVF : RES_OK;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        prem_d = step_prem;
        dvd_d  = {dvd_q[W-2:0], step_qbit};
        if (cnt_q == CNT_LAST) state_d = DONE;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      DONE: begin
        state_d = IDLE;
        valid_d = 1'b1;
        if (code_q == RES_DZ) begin
          quot_d = '1;
          rem_d  = dvd_q;
          err_d  = 1'b1;
          ovf_d  = 1'b0;
        end else begin
          quot_d = q_ext;
          rem_d  = r_fix;
          err_d  = 1'b0;
          ovf_d  = (code_q == RES_OVF);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prem_q    <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      num_neg_q <= 1'b0;
      q_neg_q   <= 1'b0;
      code_q    <= RES_OK;
      quot_q    <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prem_q    <= prem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      num_neg_q <= num_neg_d;
      q_neg_q   <= q_neg_d;
      code_q    <= code_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end

  // valid is the registered result strobe of DONE, so it lands in the cycle
  // after DONE; that cycle is already IDLE and may accept the next start.
  assign busy      = (state_q != IDLE);
  assign valid     = valid_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign error     = err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: one unsigned and one signed instance
// (W=16, OUT_W=32) sharing clock, reset and operand buses.
module tb_seq_divider;

  localparam int W     = 16;
  localparam int OUT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_u = 1'b0, start_s = 1'b0;
  logic [W-1:0]     num = '0, den = '0;
  logic             busy_u, valid_u, err_u, ovf_u;
  logic             busy_s, valid_s, err_s, ovf_s;
  logic [OUT_W-1:0] quot_u, quot_s;
  logic [W-1:0]     rem_u, rem_s;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_divider #(.W(W), .OUT_W(OUT_W), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .start(start_u), .numerator(num), .denominator(den),
    .busy(busy_u), .valid(valid_u), .quotient(quot_u), .remainder(rem_u),
    .error(err_u), .ovf(ovf_u));

  seq_divider #(.W(W), .OUT_W(OUT_W), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .start(start_s), .numerator(num), .denominator(den),
    .busy(busy_s), .valid(valid_s), .quotient(quot_s), .remainder(rem_s),
    .error(err_s), .ovf(ovf_s));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits for valid on the selected instance; returns edges counted from
  // first_edge, or 0 when the budget runs out.
  task automatic wait_valid(input bit s, input int first_edge, output int lat);
    lat = 0;
    for (int i = first_edge; i <= 40; i++) begin
      @(posedge clk); #1;
      if ((s ? valid_s : valid_u) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input bit s, input logic [W-1:0] n, input logic [W-1:0] d,
                        input int exp_lat, input logic [OUT_W-1:0] eq, input logic [W-1:0] er,
                        input bit ee, input bit eo);
    int lat;
    @(negedge clk);
    num = n; den = d;
    if (s) start_s = 1'b1; else start_u = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0; start_u = 1'b0;
    chk({tag, ".busy"}, s ? busy_s : busy_u, 1'b1);
    wait_valid(s, 1, lat);
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".q"},   s ? quot_s : quot_u, eq);
    chk({tag, ".r"},   s ? rem_s  : rem_u,  er);
    chk({tag, ".err"}, s ? err_s  : err_u,  ee);
    chk({tag, ".ovf"}, s ? ovf_s  : ovf_u,  eo);
  endtask

  initial begin
    int lat, t_prev, t_acc;
    logic [W-1:0] cn, cd;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy_u",  busy_u,  1'b0);
    chk("rst.valid_u", valid_u, 1'b0);
    chk("rst.q_u",     quot_u,  32'h0);
    chk("rst.r_u",     rem_u,   16'h0);
    chk("rst.err_u",   err_u,   1'b0);
    chk("rst.ovf_u",   ovf_u,   1'b0);
    chk("rst.busy_s",  busy_s,  1'b0);
    chk("rst.q_s",     quot_s,  32'h0);
    @(negedge clk); rst = 1'b0;

    // Unsigned
    run_op("u65535_2",  1'b0, 16'hFFFF, 16'h0002, 17, 32'h0000_7FFF, 16'h0001, 1'b0, 1'b0);
    run_op("u_divzero", 1'b0, 16'hFFFF, 16'h0000,  1, 32'hFFFF_FFFF, 16'hFFFF, 1'b1, 1'b0);
    run_op("u5_7",      1'b0, 16'd5,    16'd7,    17, 32'd0,         16'd5,    1'b0, 1'b0);
    run_op("u8000_ffff",1'b0, 16'h8000, 16'hFFFF, 17, 32'd0,         16'h8000, 1'b0, 1'b0);
    // Signed
    run_op("s-7_2",     1'b1, 16'hFFF9, 16'h0002, 17, 32'hFFFF_FFFD, 16'hFFFF, 1'b0, 1'b0);
    run_op("s_min_m1",  1'b1, 16'h8000, 16'hFFFF, 17, 32'hFFFF_8000, 16'h0000, 1'b0, 1'b1);
    run_op("s100_-7",   1'b1, 16'd100,  16'hFFF9, 17, 32'hFFFF_FFF2, 16'd2,    1'b0, 1'b0);
    run_op("s0_5",      1'b1, 16'd0,    16'd5,    17, 32'd0,         16'd0,    1'b0, 1'b0);
    run_op("s-1_0",     1'b1, 16'hFFFF, 16'h0000,  1, 32'hFFFF_FFFF, 16'hFFFF, 1'b1, 1'b0);

    // start pulsed mid-RUN is ignored
    @(negedge clk); num = 16'd1000; den = 16'd3; start_u = 1'b1;
    @(posedge clk); #1; start_u = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); num = 16'd5; den = 16'd5; start_u = 1'b1;
    @(negedge clk); start_u = 1'b0;
    wait_valid(1'b0, 5, lat);
    chk("ign.lat", lat, 17);
    chk("ign.q", quot_u, 32'd333);
    chk("ign.r", rem_u, 16'd1);

    // reset mid-RUN aborts and clears outputs
    @(negedge clk); num = 16'd1000; den = 16'd3; start_u = 1'b1;
    @(posedge clk); #1; start_u = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort.busy",  busy_u,  1'b0);
    chk("abort.valid", valid_u, 1'b0);
    chk("abort.q",     quot_u,  32'd0);
    chk("abort.r",     rem_u,   16'd0);
    chk("abort.err",   err_u,   1'b0);
    chk("abort.ovf",   ovf_u,   1'b0);
    @(negedge clk); rst = 1'b0;
    run_op("u100_7", 1'b0, 16'd100, 16'd7, 17, 32'd14, 16'd2, 1'b0, 1'b0);

    // start held high, operands changed while busy
    @(negedge clk);
    num = 16'($urandom); den = 16'($urandom_range(1, 65535)); start_u = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 8; k++) begin
      lat = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (!busy_u) begin lat = 1; break; end
      end
      chk("hold.idle", lat, 1);
      @(posedge clk); #1;
      t_acc = cyc;
      cn = num; cd = den;
      chk("hold.busy", busy_u, 1'b1);
      if (k > 0) begin
        chk("hold.period", t_acc - t_prev, W + 2);
        chk("hold.no_dbl_valid", valid_u, 1'b0);
      end
      t_prev = t_acc;
      num = 16'($urandom);
      den = (k == 3) ? 16'd1 : 16'($urandom_range(1, 65535));
      wait_valid(1'b0, 1, lat);
      if (k == 7) start_u = 1'b0;
      chk("hold.lat", lat, 17);
      chk("hold.q", quot_u, 32'(cn / cd));
      chk("hold.r", rem_u,  16'(cn % cd));
      chk("hold.err", err_u, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
